// File: rtl/logic_writeback_stage.sv
// Byte-lane merge over old destination values, queued in a DEPTH-entry FIFO; 1-cycle accept-to-visible, no full-queue bypass.
// Optional LOGIC_WB_ZERO_FLAG_EN adds per-entry zero flags out_zero1/out_zero2 captured at push time.
module logic_writeback_stage #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_select,
    input  logic [31:0]                  in_y1,
    input  logic [31:0]                  in_y2,
    input  logic [31:0]                  in_old1,
    input  logic [31:0]                  in_old2,
    input  logic [TAG_W-1:0]             in_tag1,
    input  logic [TAG_W-1:0]             in_tag2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_d1,
    output logic [31:0]                  out_d2,
    output logic [TAG_W-1:0]             out_tag1,
    output logic [TAG_W-1:0]             out_tag2,
    output logic [$clog2(DEPTH+1)-1:0]   out_count
`ifdef LOGIC_WB_ZERO_FLAG_EN
    ,
    output logic                         out_zero1,
    output logic                         out_zero2
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0]      d1;
        logic [31:0]      d2;
        logic [TAG_W-1:0] tag1;
        logic [TAG_W-1:0] tag2;
`ifdef LOGIC_WB_ZERO_FLAG_EN
        logic             zero1;
        logic             zero2;
`endif
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [31:0] w_d1;
    logic [31:0] w_d2;
    entry_t      w_wr_entry;
    entry_t      w_head;
    logic        w_push;
    logic        w_pop;

    always_comb begin
        w_d1 = '0;
        w_d2 = '0;
        for (int i = 0; i < 4; i++) begin
            w_d1[8*i +: 8] = in_select[i] ? in_y1[8*i +: 8] : in_old1[8*i +: 8];
            w_d2[8*i +: 8] = in_select[i] ? in_y2[8*i +: 8] : in_old2[8*i +: 8];
        end
    end

    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.d1   = w_d1;
        w_wr_entry.d2   = w_d2;
        w_wr_entry.tag1 = in_tag1;
        w_wr_entry.tag2 = in_tag2;
`ifdef LOGIC_WB_ZERO_FLAG_EN
        w_wr_entry.zero1 = (w_d1 == 32'd0);
        w_wr_entry.zero2 = (w_d2 == 32'd0);
`endif
    end

    // A pop does not free a slot for the same-cycle push when full.
    assign in_ready  = !rst && !flush && (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: stale entries are masked by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_d1    = out_valid ? w_head.d1   : '0;
    assign out_d2    = out_valid ? w_head.d2   : '0;
    assign out_tag1  = out_valid ? w_head.tag1 : '0;
    assign out_tag2  = out_valid ? w_head.tag2 : '0;
    assign out_count = r_count;
`ifdef LOGIC_WB_ZERO_FLAG_EN
    assign out_zero1 = out_valid ? w_head.zero1 : 1'b0;
    assign out_zero2 = out_valid ? w_head.zero2 : 1'b0;
`endif

endmodule

// File: doc/logic_writeback_stage.md
# logic_writeback_stage

Byte-lane merge and writeback buffer directly downstream of the ALU logic unit. Takes the unit's two 32-bit results (Y1, Y2) plus the same 4-bit lane select that drove it. Merges selected byte lanes over the old destination values so unselected lanes are preserved rather than zeroed, and queues the merged pair with destination tags in a small FIFO. Drains to the register-file write port over a valid/ready handshake.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- TAG_W, 5, destination register tag width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous queue clear, same effect on state as rst
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept this cycle
- in_select  input  4  byte-lane select; bit i covers bits [8i+7:8i]
- in_y1, in_y2  input  32  logic unit results Y1, Y2
- in_old1, in_old2  input  32  current destination register contents
- in_tag1, in_tag2  input  TAG_W  destination tags for the two results
- out_valid  output  1  head entry available
- out_ready  input  1  register-file port accepts head
- out_d1, out_d2  output  32  merged data at head
- out_tag1, out_tag2  output  TAG_W  tags at head
- out_count  output  $clog2(DEPTH+1)  occupied entries

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Merge per lane i, applied independently to each result:
  - d1[8i+7:8i] = in_select[i] ? in_y1 lane i : in_old1 lane i.
  - d2 is formed the same way from in_y2 and in_old2.
  - in_select = 4'b0000 writes old values unchanged; this is legal and still enqueued.
- Queue: circular buffer with wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH. count is tracked separately.
- Pop: out_valid && out_ready.
- in_ready = !rst && !flush && (count != DEPTH). A pop in the same cycle does not open a slot when full; there is no full-queue bypass.
- Simultaneous push and pop (count in 1..DEPTH-1): both pointers advance, count unchanged.
- Push only: count+1. Pop only: count-1.
- out_valid = (count != 0).
- out_d*/out_tag* show the head entry when out_valid is 1 and are forced to 0 when empty.
- Head data is stable while out_valid && !out_ready.
- rst or flush: pointers and count go to 0 and in-flight entries are discarded. rst takes priority; flush in the same cycle as a push discards the push.
- Reset values: out_valid 0, out_d1/out_d2 0, out_tag1/out_tag2 0, out_count 0, in_ready 0 while rst or flush is high.

## Timing
- Accept-to-visible latency is 1 cycle: an entry pushed into an empty queue at edge N drives out_valid=1 after edge N.
- Throughput is one entry per cycle when out_ready is held high.
- in_ready and out_valid are functions of registered count (plus rst/flush) only. No combinational path from out_ready to in_ready.
- in_select, in_y*, in_old*, in_tag* are sampled only on accept edges.

## Configuration
- LOGIC_WB_ZERO_FLAG_EN
  - Defined: adds outputs out_zero1 and out_zero2 (1 bit each) = (out_d1 == 0) and (out_d2 == 0). Each flag is stored per entry at push time, not recomputed at output. Both flags are 0 when the queue is empty and after reset.
  - Undefined: the ports and storage are absent; behaviour is otherwise identical.

## Test plan
- Lane merge: in_y1=32'hAABBCCDD, in_old1=32'h11223344, in_select=4'b0101 -> after one edge, out_d1=32'h11BB33DD, out_valid=1, out_count=1.
- Fill and stall: out_ready=0, push DEPTH=4 entries -> in_ready=0 after 4th edge, out_count=4. A 5th in_valid is ignored, and the head stays at entry 0 data.
- Streaming: in_valid=out_ready=1 for 10 cycles with incrementing tags -> out_count stays 1, tags emerge in order 0..9 one cycle late, pointers wrap cleanly past DEPTH.
- Full with simultaneous pop: count=4, out_ready=1, in_valid=1 -> in_ready=0, count drops to 3, no entry lost or duplicated.
- Flush mid-operation: 3 entries queued, flush=1 with in_valid=1 -> next cycle out_valid=0, out_count=0, out_d1=0, and the pushed entry is absent.
- Zero flag (with LOGIC_WB_ZERO_FLAG_EN): in_select=4'b1111, in_y2=0, in_y1=1 -> out_zero2=1, out_zero1=0. Check the same vector in a build without the macro compiles and matches on all other ports.
